irq_priority_encoder: RTL and testbench

- Interrupt front end for the 16-bit pipelined core.
- Captures 8 request lines into a pending register and applies a mask.
- Priority-encodes the highest-priority unmasked pending line to a 3-bit ID.
- Presents that ID to the control unit over a valid/ack handshake, then tracks the in-service interrupt until end-of-interrupt (EOI).

---
 rtl/irq_pkg.sv | 21 ++
 rtl/priority_encoder_8x3.sv | 21 ++
 rtl/irq_priority_encoder.sv | 147 ++++++++++++++
 tb/tb_irq_priority_encoder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared constants for the interrupt front end.
//   N_IRQ / ID_W : number of request lines and width of an interrupt ID.
//   ST_*         : FSM state encodings (IDLE, REQ, SERVICE).
//   onehot_from_id : ID -> one-hot line mask, used to clear a pending bit on ack.
package irq_pkg;

    localparam int N_IRQ = 8;
    localparam int ID_W  = 3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    function automatic logic [N_IRQ-1:0] onehot_from_id(input logic [ID_W-1:0] id);
        logic [N_IRQ-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/priority_encoder_8x3.sv
// Combinational 8-to-3 priority encoder, lowest index wins.
// Inverse of the 3x8 decoder used elsewhere in the core.
//   cand [7:0] : candidate lines
//   id   [2:0] : index of the lowest set bit of cand (0 when none set)
//   any        : at least one candidate is set
module priority_encoder_8x3 (
    input  logic [7:0] cand,
    output logic [2:0] id,
    output logic       any
);

    always_comb begin
        id  = 3'd0;
        any = |cand;
        // Scan from the top down so the lowest set index is written last.
        for (int i = 7; i >= 0; i--) begin
            if (cand[i]) id = 3'(i);
        end
    end

endmodule

// File: rtl/irq_priority_encoder.sv
// Interrupt front end: captures request lines into a pending register,
// masks and priority-encodes them, presents one ID over a valid/ack
// handshake and tracks the in-service handler until end-of-interrupt.
//
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   irq_in       : raw request lines (already synchronous to clk)
//   irq_mask     : 1 = line masked (stays pending, never selected)
//   irq_ack      : control unit accepts the presented ID
//   eoi          : control unit finished the in-service handler
//   irq_valid    : an ID is presented on irq_id
//   irq_id       : presented ID, stable while irq_valid is high
//   isr_id       : ID currently (or most recently) in service
//   in_service   : a handler is active
//   pending      : pending register, for status reads
//
// Build option:
//   IRQ_LEVEL_TRIG_EN : level-triggered capture; a line re-pends every
//                       cycle it is high and the edge detector is removed.
//
// The encoder is a fixed 8x3 block, so N_IRQ must be 8 and ID_W 3.
module irq_priority_encoder
    import irq_pkg::*;
#(
    parameter int N_IRQ = irq_pkg::N_IRQ,
    parameter int ID_W  = irq_pkg::ID_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [N_IRQ-1:0] irq_mask,
    input  logic             irq_ack,
    input  logic             eoi,
    output logic             irq_valid,
    output logic [ID_W-1:0]  irq_id,
    output logic [ID_W-1:0]  isr_id,
    output logic             in_service,
    output logic [N_IRQ-1:0] pending
);

    logic [1:0]       state_q, state_d;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic             irq_valid_q, irq_valid_d;
    logic [ID_W-1:0]  irq_id_q, irq_id_d;
    logic [ID_W-1:0]  isr_id_q, isr_id_d;
    logic             in_service_q, in_service_d;

    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] clr;
    logic [N_IRQ-1:0] cand;
    logic [2:0]       sel_id;
    logic             any;
    logic             ack_take;

`ifdef IRQ_LEVEL_TRIG_EN
    // Level mode: the line itself re-pends every cycle it is high.
    assign rise = irq_in;
`else
    logic [N_IRQ-1:0] irq_q;

    // irq_q resets to 0, so a line held high through reset is captured once.
    always_ff @(posedge clk) begin
        if (!rst_n) irq_q <= '0;
        else        irq_q <= irq_in;
    end

    assign rise = irq_in & ~irq_q;
`endif

    assign cand = pending_q & ~irq_mask;

    priority_encoder_8x3 u_enc (
        .cand (cand),
        .id   (sel_id),
        .any  (any)
    );

    // Only an ack in REQ is honoured; eoi in the same cycle is dropped.
    assign ack_take = (state_q == ST_REQ) && irq_ack;

    always_comb begin
        clr = ack_take ? onehot_from_id(irq_id_q) : '0;
        // Set after clear: a new rise on the bit being acked keeps it pending.
        pending_d = (pending_q & ~clr) | rise;
    end

    always_comb begin
        state_d      = state_q;
        irq_valid_d  = irq_valid_q;
        irq_id_d     = irq_id_q;
        isr_id_d     = isr_id_q;
        in_service_d = in_service_q;
        case (state_q)
            ST_IDLE: begin
                if (any) begin
                    irq_id_d    = ID_W'(sel_id);
                    irq_valid_d = 1'b1;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                // Presented ID is never retracted, even if masked or outranked.
                if (irq_ack) begin
                    isr_id_d     = irq_id_q;
                    in_service_d = 1'b1;
                    irq_valid_d  = 1'b0;
                    state_d      = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (eoi) begin
                    in_service_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                irq_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            irq_valid_q  <= 1'b0;
            irq_id_q     <= '0;
            isr_id_q     <= '0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            irq_valid_q  <= irq_valid_d;
            irq_id_q     <= irq_id_d;
            isr_id_q     <= isr_id_d;
            in_service_q <= in_service_d;
        end
    end

    assign irq_valid  = irq_valid_q;
    assign irq_id     = irq_id_q;
    assign isr_id     = isr_id_q;
    assign in_service = in_service_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_irq_priority_encoder.sv
// Bench for irq_priority_encoder: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model of the
// interrupt controller kept here.
module tb_irq_priority_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irq_in, irq_mask;
    logic       irq_ack, eoi;
    logic       irq_valid, in_service;
    logic [2:0] irq_id, isr_id;
    logic [7:0] pending;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    irq_priority_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_in     (irq_in),
        .irq_mask   (irq_mask),
        .irq_ack    (irq_ack),
        .eoi        (eoi),
        .irq_valid  (irq_valid),
        .irq_id     (irq_id),
        .isr_id     (isr_id),
        .in_service (in_service),
        .pending    (pending)
    );

    // Behavioural model: pending lines as a bit array, controller phase
    // as "waiting / offering / handling".
    bit m_pend [8];
    bit m_prev [8];
    bit m_offer;
    int m_id;
    int m_isr;
    bit m_busy;

    function automatic logic [7:0] m_pend_vec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [7:0] in, input logic [7:0] msk,
                              input logic ack, input logic e, input logic rn);
        bit np [8];
        int first;
        if (!rn) begin
            for (int i = 0; i < 8; i++) begin m_pend[i] = 0; m_prev[i] = 0; end
            m_offer = 0; m_id = 0; m_isr = 0; m_busy = 0;
            return;
        end
        for (int i = 0; i < 8; i++) begin
            bit newreq, acked;
`ifdef IRQ_LEVEL_TRIG_EN
            newreq = in[i];
`else
            newreq = in[i] && !m_prev[i];
`endif
            acked = m_offer && ack && (m_id == i);
            np[i] = (m_pend[i] && !acked) || newreq;
        end
        if (m_offer) begin
            if (ack) begin m_isr = m_id; m_busy = 1; m_offer = 0; end
        end else if (m_busy) begin
            if (e) m_busy = 0;
        end else begin
            first = -1;
            for (int i = 7; i >= 0; i--) if (m_pend[i] && !msk[i]) first = i;
            if (first >= 0) begin m_offer = 1; m_id = first; end
        end
        for (int i = 0; i < 8; i++) begin m_pend[i] = np[i]; m_prev[i] = in[i]; end
    endtask

    // Drive inputs, take one edge, update model, sample 1 time unit later.
    task automatic step(input logic [7:0] in, input logic [7:0] msk = 8'h00,
                        input logic ack = 1'b0, input logic e = 1'b0,
                        input logic rn = 1'b1);
        irq_in = in; irq_mask = msk; irq_ack = ack; eoi = e; rst_n = rn;
        @(posedge clk);
        model_edge(in, msk, ack, e, rn);
        #1;
        chk("irq_valid",  32'(irq_valid),  32'(m_offer));
        chk("irq_id",     32'(irq_id),     32'(m_id));
        chk("isr_id",     32'(isr_id),     32'(m_isr));
        chk("in_service", 32'(in_service), 32'(m_busy));
        chk("pending",    32'(pending),    32'(m_pend_vec()));
    endtask

    initial begin
        irq_in = '0; irq_mask = '0; irq_ack = 0; eoi = 0; rst_n = 0;
        #2;
        step(8'h00, 8'h00, 0, 0, 0);
        step(8'h00, 8'h00, 0, 0, 0);
        chk("rst_valid", 32'(irq_valid), 0);
        chk("rst_pend",  32'(pending),   0);
        chk("rst_insvc", 32'(in_service), 0);

`ifndef IRQ_LEVEL_TRIG_EN
        // Single pulse on line 5.
        step(8'h20);             chk("p5_pend", 32'(pending), 32'h20);
        step(8'h00);             chk("p5_id", 32'(irq_id), 5); chk("p5_vld", 32'(irq_valid), 1);
        step(8'h00, 0, 1);       chk("p5_isr", 32'(isr_id), 5); chk("p5_insvc", 32'(in_service), 1);
                                 chk("p5_clr", 32'(pending), 0);
        step(8'h00, 0, 0, 1);    chk("p5_eoi", 32'(in_service), 0);

        // Lines 0 and 7 together: 0 first, 7 the cycle after eoi.
        step(8'h81);
        step(8'h00);             chk("p81_first", 32'(irq_id), 0);
        step(8'h00, 0, 1);
        step(8'h00, 0, 0, 1);    chk("p81_gap", 32'(irq_valid), 0);
        step(8'h00);             chk("p81_second", 32'(irq_id), 7); chk("p81_vld", 32'(irq_valid), 1);
        step(8'h00, 0, 1);
        step(8'h00, 0, 0, 1);

        // Masked pending line is held off until unmasked.
        step(8'h04, 8'h04);
        step(8'h00, 8'h04);      chk("msk_hold", 32'(irq_valid), 0);
        step(8'h00, 8'h00);      chk("msk_drop", 32'(irq_id), 2); chk("msk_vld", 32'(irq_valid), 1);
        step(8'h00, 0, 1);
        step(8'h00, 0, 0, 1);

        // No retraction in REQ.
        step(8'h08);
        step(8'h00);
        step(8'h02, 8'h08);      chk("noretr", 32'(irq_id), 3);
        step(8'h00, 8'h08, 1);   chk("noretr_isr", 32'(isr_id), 3);
        step(8'h00, 8'h08, 0, 1);
        step(8'h00);             chk("noretr_next", 32'(irq_id), 1);
        step(8'h00, 0, 1);
        step(8'h00, 0, 0, 1);

        // Ack collides with a new rise on the same line; stray ack/eoi.
        step(8'h10);
        step(8'h00);
        step(8'h10, 0, 1);       chk("col_pend", 32'(pending), 32'h10);
        step(8'h00, 0, 1);       chk("stray_ack", 32'(in_service), 1);
        step(8'h00, 0, 0, 1);
        step(8'h00);             chk("col_repres", 32'(irq_id), 4);
        step(8'h00, 0, 1);
        step(8'h00, 0, 0, 1);
        step(8'h00, 0, 0, 1);    chk("stray_eoi", 32'(irq_valid), 0);

        // Reset in REQ.
        step(8'h40);
        step(8'h40);             chk("rq_vld", 32'(irq_valid), 1);
        step(8'h40, 0, 0, 0, 0); chk("rq_rst_vld", 32'(irq_valid), 0); chk("rq_rst_pend", 32'(pending), 0);
        step(8'h40);             chk("rq_held_cap", 32'(pending), 32'h40);
        step(8'h00, 0, 0, 0, 0);
`else
        // Level mode: a held line re-pends right after its ack.
        step(8'h01);
        step(8'h01);             chk("lvl_vld", 32'(irq_valid), 1);
        step(8'h01, 0, 1);       chk("lvl_repend", 32'(pending), 32'h01);
        step(8'h00, 0, 0, 1);
        step(8'h00, 0, 0, 0, 0);
`endif

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            logic [7:0] in, msk;
            in  = 8'($urandom & $urandom & $urandom);
            msk = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            step(in, msk, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 199) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
